// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align -- load/store alignment unit in front of a byte-enabled word memory
//
// Converts one byte-addressed RISC-V load or store (Funct3 coded) into one or
// two word-aligned memory accesses. An access that crosses a word boundary is
// split into two back-to-back accesses, w0 and then w1. Load data is
// reassembled and then sign- or zero-extended. Completion is reported with a
// single-cycle rsp_valid pulse.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while idle
//   MemRead/MemWrite  request kind (both set -> load, neither -> ignored)
//   Funct3            access size / signedness (instruction bits 14:12)
//   addr, wd          byte address and store data
//   rsp_valid, rd     completion pulse and extended load data
//   mem_addr          word-aligned memory address
//   mem_re, mem_we    read strobe and per-lane write strobes
//   mem_wd            lane-aligned write data
//   mem_rdata         memory read data, valid the cycle after mem_re
// ---------------------------------------------------------------------------
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE0 = 2'd1;
  localparam logic [1:0] S_ISSUE1 = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Funct3[2] only selects signedness, so the size comes from the low bits.
  function automatic logic [1:0] size_of(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Lanes of w0 touched by the access (bits shifted past lane 3 belong to w1).
  function automatic logic [3:0] strobe_w0(input logic [1:0] sz, input logic [1:0] o);
    logic [3:0] m;
    m = lane_mask(sz) << o;
    return m;
  endfunction

  // Lanes of w1 touched by a split access: the part of the mask that spilled
  // past lane 3. Only the bytes that belong to the access are strobed.
  function automatic logic [3:0] strobe_w1(input logic [1:0] sz, input logic [1:0] o);
    return lane_mask(sz) >> (3'd4 - {1'b0, o});
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [2*DATA_W-1:0] comb,
                                                    input logic [1:0] o,
                                                    input logic [1:0] sz,
                                                    input logic sgn);
    logic [DATA_W-1:0] field;
    field = DATA_W'(comb >> {o, 3'b000});
    case (sz)
      SZ_BYTE: return sgn ? {{24{field[7]}}, field[7:0]} : {24'h000000, field[7:0]};
      SZ_HALF: return sgn ? {{16{field[15]}}, field[15:0]} : {16'h0000, field[15:0]};
      default: return field;
    endcase
  endfunction

  // State and registered outputs
  logic [1:0]            state_r;
  logic                  ready_r;
  logic                  rsp_r;
  logic [DATA_W-1:0]     rd_r;
  logic [DM_ADDRESS-1:0] mem_addr_r;
  logic                  mem_re_r;
  logic [3:0]            mem_we_r;
  logic [DATA_W-1:0]     mem_wd_r;
  logic [DATA_W-1:0]     lo_r;

  // Request captured at accept
  logic [DM_ADDRESS-1:0] addr_r;
  logic [2:0]            f3_r;
  logic [DATA_W-1:0]     wd_r;
  logic                  load_r;

  // Next-state values
  logic [1:0]            state_nxt_s;
  logic                  rsp_nxt_s;
  logic [DATA_W-1:0]     rd_nxt_s;
  logic [DM_ADDRESS-1:0] mem_addr_nxt_s;
  logic                  mem_re_nxt_s;
  logic [3:0]            mem_we_nxt_s;
  logic [DATA_W-1:0]     mem_wd_nxt_s;
  logic [DATA_W-1:0]     lo_nxt_s;

  // Decode of the incoming request (drives the ISSUE0 outputs at accept)
  logic                  accept_s;
  logic [1:0]            in_sz_s;
  logic [1:0]            in_o_s;
  logic [DM_ADDRESS-1:0] in_w0_s;

  // Decode of the captured request
  logic [1:0]            sz_s;
  logic [1:0]            o_s;
  logic                  split_s;
  logic [DM_ADDRESS-1:0] w0_s;
  logic [DM_ADDRESS-1:0] w1_s;
  logic [5:0]            hi_shift_s;
  logic [2*DATA_W-1:0]   comb_s;

  assign accept_s = req_valid & ready_r & (MemRead | MemWrite);
  assign in_sz_s  = size_of(Funct3[1:0]);
  assign in_o_s   = addr[1:0];
  assign in_w0_s  = {addr[DM_ADDRESS-1:2], 2'b00};

  assign sz_s    = size_of(f3_r[1:0]);
  assign o_s     = addr_r[1:0];
  assign split_s = ((sz_s == SZ_HALF) & (o_s == 2'b11)) | ((sz_s == SZ_WORD) & (o_s != 2'b00));
  assign w0_s    = {addr_r[DM_ADDRESS-1:2], 2'b00};
  // Natural wrap to address 0 above the top word.
  assign w1_s    = w0_s + {{(DM_ADDRESS-3){1'b0}}, 3'b100};
  // Store bytes that spill into w1 start at byte (4 - o) of wd.
  assign hi_shift_s = {3'd4 - {1'b0, o_s}, 3'b000};
  assign comb_s  = split_s ? {mem_rdata, lo_r} : {{DATA_W{1'b0}}, mem_rdata};

  // Next-state and next-output logic; memory outputs are idle unless issuing.
  always_comb begin
    state_nxt_s    = state_r;
    rsp_nxt_s      = 1'b0;
    rd_nxt_s       = rd_r;
    mem_addr_nxt_s = {DM_ADDRESS{1'b0}};
    mem_re_nxt_s   = 1'b0;
    mem_we_nxt_s   = 4'b0000;
    mem_wd_nxt_s   = {DATA_W{1'b0}};
    lo_nxt_s       = lo_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s    = S_ISSUE0;
          mem_addr_nxt_s = in_w0_s;
          if (MemRead) begin
            mem_re_nxt_s = 1'b1;
          end else begin
            mem_we_nxt_s = strobe_w0(in_sz_s, in_o_s);
            mem_wd_nxt_s = wd << {in_o_s, 3'b000};
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE0: begin
        if (split_s) begin
          state_nxt_s    = S_ISSUE1;
          mem_addr_nxt_s = w1_s;
          if (load_r) begin
            mem_re_nxt_s = 1'b1;
          end else begin
            mem_we_nxt_s = strobe_w1(sz_s, o_s);
            mem_wd_nxt_s = wd_r >> hi_shift_s;
          end
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_ISSUE1: begin
        // mem_rdata now carries the w0 word.
        if (load_r) begin
          lo_nxt_s = mem_rdata;
        end else begin
          lo_nxt_s = lo_r;
        end
        state_nxt_s = S_DONE;
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        rsp_nxt_s   = 1'b1;
        if (load_r) begin
          rd_nxt_s = extend_load(comb_s, o_s, sz_s, ~f3_r[2]);
        end else begin
          rd_nxt_s = rd_r;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, response and memory-interface registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      ready_r    <= 1'b1;
      rsp_r      <= 1'b0;
      rd_r       <= {DATA_W{1'b0}};
      mem_addr_r <= {DM_ADDRESS{1'b0}};
      mem_re_r   <= 1'b0;
      mem_we_r   <= 4'b0000;
      mem_wd_r   <= {DATA_W{1'b0}};
      lo_r       <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      ready_r    <= (state_nxt_s == S_IDLE);
      rsp_r      <= rsp_nxt_s;
      rd_r       <= rd_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      mem_re_r   <= mem_re_nxt_s;
      mem_we_r   <= mem_we_nxt_s;
      mem_wd_r   <= mem_wd_nxt_s;
      lo_r       <= lo_nxt_s;
    end
  end

  // Request capture; inputs are ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {DM_ADDRESS{1'b0}};
      f3_r   <= 3'b000;
      wd_r   <= {DATA_W{1'b0}};
      load_r <= 1'b0;
    end else if (accept_s) begin
      addr_r <= addr;
      f3_r   <= Funct3;
      wd_r   <= wd;
      load_r <= MemRead;
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_r;
  assign rd        = rd_r;
  assign mem_addr  = mem_addr_r;
  assign mem_re    = mem_re_r;
  assign mem_we    = mem_we_r;
  assign mem_wd    = mem_wd_r;

endmodule
